// File: rtl/mem_stage_ls.sv
// MEM stage load/store unit: valid/ready request, programmable wait states,
// B/H/W loads and stores on an internal word array. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage_ls #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] result_alu,
  input  logic [XLEN-1:0]   data_rs2,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   read_data,
  output logic [XLEN-1:0]   result_alu_to_mux,
  output logic              mem_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                mr_q, mr_d, mw_q, mw_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdat_q, wdat_d;
  logic [XLEN-1:0]     rd_q, rd_d, res_q, res_d;
  logic                err_q, err_d;

  logic [XLEN-1:0]     mem_q [0:DEPTH-1];

  logic                accept, illegal, misal, err, we;
  logic [ADDR_W-1:0]   eff_addr;
  logic [1:0]          lane;
  logic [ADDR_W-3:0]   idx;
  logic [XLEN-1:0]     word, shifted, load_val, wdata;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [3:0]          be;

  assign req_ready         = (state_q != BUSY);
  assign rsp_valid         = (state_q == RESP);
  assign read_data         = rd_q;
  assign result_alu_to_mux = res_q;
  assign mem_err           = err_q;
  assign accept            = req_valid && req_ready;

  // Access decode works on the latched request fields.
  always_comb begin
    illegal = (f3_q == 3'd3) || (f3_q[2:1] == 2'b11);
    misal   = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
              ((f3_q == 3'd2) && (addr_q[1:0] != 2'b00));
    eff_addr = addr_q;
`ifdef MEM_MISALIGN_TRAP_EN
    err = (mr_q || mw_q) && (illegal || misal);
`else
    err = (mr_q || mw_q) && illegal;
    if (f3_q[1:0] == 2'b01) eff_addr[0] = 1'b0;
    else if (f3_q == 3'd2)  eff_addr[1:0] = 2'b00;
`endif
    lane     = eff_addr[1:0];
    idx      = eff_addr[ADDR_W-1:2];
    word     = mem_q[idx];
    shifted  = word >> {lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (f3_q)
      3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_val = {24'd0, byte_sel};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_val = {16'd0, half_sel};
      3'd2:    load_val = word;
      default: load_val = '0;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        wdata = {4{wdat_q[7:0]}};
        be    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata = {2{wdat_q[15:0]}};
        be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = wdat_q;
        be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    we      = 1'b0;
    case (state_q)
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          we      = mw_q && !err;
          rd_d    = (mr_q && !mw_q && !err) ? load_val : '0;
          res_d   = XLEN'(addr_q);
          err_d   = err;
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          mr_d    = memread;
          mw_d    = memwrite;
          f3_d    = funct3;
          addr_d  = result_alu;
          wdat_d  = data_rs2;
          cnt_d   = 4'(WAIT_CYC);
          state_d = BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; writes only fire from BUSY, so reset blocks them.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls (WAIT_CYC=1); expectations follow MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_ls;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [9:0]  result_alu = '0;
  logic [31:0] data_rs2 = '0;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic [31:0] result_alu_to_mux;
  logic        mem_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] w10;
  logic [31:0] exp_rd [3];
  logic [9:0]  addrs [3];
  int k;

  always #5 clk = ~clk;

  mem_stage_ls #(.XLEN(32), .ADDR_W(10), .WAIT_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .memread(memread), .memwrite(memwrite), .funct3(funct3),
    .result_alu(result_alu), .data_rs2(data_rs2), .rsp_valid(rsp_valid),
    .read_data(read_data), .result_alu_to_mux(result_alu_to_mux), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Issue one request from IDLE, wait for the response and check latency and outputs.
  task automatic do_req(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [9:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err);
    int lat;
    @(negedge clk);
    memread = mr; memwrite = mw; funct3 = f3; result_alu = a; data_rs2 = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'd3);
    check({tag, ".rd"}, read_data, exp_data);
    check({tag, ".err"}, {31'd0, mem_err}, {31'd0, exp_err});
    check({tag, ".res"}, result_alu_to_mux, {22'd0, a});
  endtask

  initial begin
    #12;
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.read_data", read_data, 32'd0);
    check("rst.res", result_alu_to_mux, 32'd0);
    check("rst.err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("sw10",  1'b0, 1'b1, 3'd2, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw10",  1'b1, 1'b0, 3'd2, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("sw10b", 1'b0, 1'b1, 3'd2, 10'h010, 32'h11223344, 32'h0, 1'b0);
    do_req("sb13",  1'b0, 1'b1, 3'd0, 10'h013, 32'h000000A5, 32'h0, 1'b0);
    do_req("lw10c", 1'b1, 1'b0, 3'd2, 10'h010, 32'h0, 32'hA5223344, 1'b0);
    do_req("lb13",  1'b1, 1'b0, 3'd0, 10'h013, 32'h0, 32'hFFFFFFA5, 1'b0);
    do_req("lbu13", 1'b1, 1'b0, 3'd4, 10'h013, 32'h0, 32'h000000A5, 1'b0);
    do_req("sh12",  1'b0, 1'b1, 3'd1, 10'h012, 32'h00008001, 32'h0, 1'b0);
    do_req("lh12",  1'b1, 1'b0, 3'd1, 10'h012, 32'h0, 32'hFFFF8001, 1'b0);
    do_req("lhu12", 1'b1, 1'b0, 3'd5, 10'h012, 32'h0, 32'h00008001, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
    do_req("lw11",  1'b1, 1'b0, 3'd2, 10'h011, 32'h0, 32'h0, 1'b1);
    do_req("sh11",  1'b0, 1'b1, 3'd1, 10'h011, 32'h00007777, 32'h0, 1'b1);
    w10 = 32'h80013344;
`else
    do_req("lw11",  1'b1, 1'b0, 3'd2, 10'h011, 32'h0, 32'h80013344, 1'b0);
    do_req("sh11",  1'b0, 1'b1, 3'd1, 10'h011, 32'h00007777, 32'h0, 1'b0);
    w10 = 32'h80017777;
`endif
    do_req("lw10d", 1'b1, 1'b0, 3'd2, 10'h010, 32'h0, w10, 1'b0);
    do_req("ill3",  1'b1, 1'b0, 3'd3, 10'h010, 32'h0, 32'h0, 1'b1);
    do_req("ill7w", 1'b0, 1'b1, 3'd7, 10'h010, 32'h12345678, 32'h0, 1'b1);
    do_req("lw10e", 1'b1, 1'b0, 3'd2, 10'h010, 32'h0, w10, 1'b0);
    do_req("nop",   1'b0, 1'b0, 3'd7, 10'h3FF, 32'hFFFFFFFF, 32'h0, 1'b0);
    do_req("both",  1'b1, 1'b1, 3'd2, 10'h014, 32'h55AA55AA, 32'h0, 1'b0);
    do_req("sw18",  1'b0, 1'b1, 3'd2, 10'h018, 32'h01234567, 32'h0, 1'b0);

    // Back-to-back: req_valid held high across three loads.
    addrs[0] = 10'h010; addrs[1] = 10'h014; addrs[2] = 10'h018;
    exp_rd[0] = w10; exp_rd[1] = 32'h55AA55AA; exp_rd[2] = 32'h01234567;
    k = 0;
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; funct3 = 3'd2; result_alu = addrs[0];
    req_valid = 1'b1;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      check($sformatf("b2b.ready%0d", n), {31'd0, req_ready}, {31'd0, (n % 3) == 2});
      check($sformatf("b2b.rsp%0d", n), {31'd0, rsp_valid}, {31'd0, (n % 3) == 2});
      if (rsp_valid === 1'b1) begin
        if (k < 3) check($sformatf("b2b.rd%0d", k), read_data, exp_rd[k]);
        k++;
        if (k < 3) result_alu = addrs[k];
        else req_valid = 1'b0;
      end
    end
    check("b2b.count", 32'(k), 32'd3);
    @(negedge clk);
    check("b2b.idle", {31'd0, rsp_valid}, 32'd0);

    // Reset while a store is in BUSY.
    do_req("sw20",  1'b0, 1'b1, 3'd2, 10'h020, 32'hCAFEF00D, 32'h0, 1'b0);
    do_req("lw20",  1'b1, 1'b0, 3'd2, 10'h020, 32'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b1; funct3 = 3'd2; result_alu = 10'h020;
    data_rs2 = 32'h0BADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid.busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid.ready", {31'd0, req_ready}, 32'd1);
    check("mid.rsp", {31'd0, rsp_valid}, 32'd0);
    check("mid.rd", read_data, 32'd0);
    check("mid.res", result_alu_to_mux, 32'd0);
    check("mid.err", {31'd0, mem_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req("lw20b", 1'b1, 1'b0, 3'd2, 10'h020, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
